// File: rtl/esm_pkg.sv
// Shared opcode constants, NOP encoding and per-entry decode record for the
// ESM fetch queue.
package esm_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] ESM_NOP = 32'h0000_0013;

  typedef struct packed {
    logic alu_src;
    logic reg_write;
    logic illegal;
  } fq_dec_t;

endpackage

// File: rtl/esm_fq_decode.sv
// Combinational opcode decode into the {ALUSrc, RegWrite, illegal} record
// stored alongside each queued instruction.
module esm_fq_decode
  import esm_pkg::*;
(
  input  logic [6:0] opcode,
  output fq_dec_t    dec
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    dec = '{alu_src: 1'b0, reg_write: 1'b0, illegal: 1'b0};
    unique case (opcode)
      OP_R:                                  dec.reg_write = 1'b1;
      OP_IMM, OP_LOAD, OP_JALR,
      OP_JAL, OP_LUI, OP_AUIPC:              dec = '{alu_src: 1'b1, reg_write: 1'b1, illegal: 1'b0};
      OP_STORE:                              dec.alu_src   = 1'b1;
      OP_BRANCH:                             ;
      default:                               dec.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/esm_fetch_queue.sv
// Instruction front-end FIFO feeding the ESM scheduling core; decode is done at
// push time. Optional same-cycle empty-queue bypass under ESM_FQ_BYPASS_EN.
module esm_fetch_queue
  import esm_pkg::*;
#(
  parameter int Instr_word_size = 32,
  parameter int FQ_DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [Instr_word_size-1:0]   in_instr,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [Instr_word_size-1:0]   Instr_out,
  output logic                         ALUSrc,
  output logic                         RegWrite,
  output logic                         illegal,
  output logic [$clog2(FQ_DEPTH):0]    count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

  typedef struct packed {
    logic [Instr_word_size-1:0] instr;
    fq_dec_t                    dec;
  } entry_t;

  entry_t        mem [FQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  fq_dec_t       push_dec;
  logic          empty, full, bypass, push, pop;

  esm_fq_decode u_decode (
    .opcode (in_instr[6:0]),
    .dec    (push_dec)
  );

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign in_ready = !full;
  assign count    = cnt;

`ifdef ESM_FQ_BYPASS_EN
  assign bypass = empty && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction is consumed directly and never occupies a slot.
  assign push = in_valid && in_ready && !bypass;
  assign pop  = !empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; count/out_valid gate every read of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: in_instr, dec: push_dec};
  end

  always_comb begin
    out_valid = 1'b0;
    Instr_out = Instr_word_size'(ESM_NOP);
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    if (bypass) begin
      out_valid = 1'b1;
      Instr_out = in_instr;
      ALUSrc    = push_dec.alu_src;
      RegWrite  = push_dec.reg_write;
      illegal   = push_dec.illegal;
    end else if (!empty) begin
      out_valid = 1'b1;
      Instr_out = mem[rd_ptr].instr;
      ALUSrc    = mem[rd_ptr].dec.alu_src;
      RegWrite  = mem[rd_ptr].dec.reg_write;
      illegal   = mem[rd_ptr].dec.illegal;
    end
  end

endmodule
